// File: rtl/cla_bist_pkg.sv
// Shared constants for the carry look-ahead adder BIST checker: default width,
// FSM state encoding and the field layout of the vector index.
package cla_bist_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Vector index layout: {cin, a, b}, with b in the low bits.
  localparam int VEC_B_LSB   = 0;
  localparam int VEC_A_LSB   = WIDTH;
  localparam int VEC_CIN_BIT = 2 * WIDTH;

endpackage

// File: rtl/cla_golden_ref.sv
// Reference adder: {cout,sum} = a + b + cin, evaluated at WIDTH+1 bits.
module cla_golden_ref #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_res
);

  assign o_res = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/cla_bist_checker.sv
// BIST engine: walks every (a, b, cin) vector through the adder under test,
// compares against the golden reference and records error count and first failure.
module cla_bist_checker
  import cla_bist_pkg::*;
#(
  parameter int WIDTH = cla_bist_pkg::WIDTH,
  parameter int VEC_W = 2 * WIDTH + 1,
  parameter int CNT_W = 2 * WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  state_t           r_state, w_next;
  logic             w_start_run;
  logic [VEC_W-1:0] r_idx;
  logic [VEC_W-1:0] w_idx_inc;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_cin;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] w_err_nxt;
  logic             r_ffv;
  logic [VEC_W-1:0] r_ffvec;
  logic             r_done, r_pass;
  logic [WIDTH:0]   w_exp;
  logic             w_mis;
  logic             w_last;

  cla_golden_ref #(.WIDTH(WIDTH)) u_ref (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_cin (r_cin),
    .o_res (w_exp)
  );

  // The adder is combinational, so the vector driven this cycle is judged now.
  assign w_mis     = ({dut_cout, dut_sum} != w_exp);
  assign w_last    = &r_idx;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_err_nxt = r_err + {{(CNT_W-1){1'b0}}, w_mis};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next      = ST_RUN;
          w_start_run = 1'b1;
        end
      end
      ST_RUN:  if (w_last) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_run) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_err   <= '0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_err <= w_err_nxt;
      if (w_mis && !r_ffv) begin
        r_ffv   <= 1'b1;
        r_ffvec <= r_idx;
      end
      // The last vector stays on the adder inputs after the run ends.
      if (w_last) begin
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == '0);
      end else begin
        r_idx <= w_idx_inc;
        r_cin <= w_idx_inc[2*WIDTH];
        r_a   <= w_idx_inc[2*WIDTH-1:WIDTH];
        r_b   <= w_idx_inc[WIDTH-1:0];
      end
    end
  end

  assign dut_a            = r_a;
  assign dut_b            = r_b;
  assign dut_cin          = r_cin;
  assign busy             = (r_state == ST_RUN);
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_cla_bist_checker.sv
// Directed bench: a behavioural adder with selectable faults sits under the
// BIST engine; results are compared against hand-computed values.
module tb_cla_bist_checker;
  import cla_bist_pkg::*;

  localparam int VEC_W = 2 * WIDTH + 1;
  localparam int CNT_W = 2 * WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dut_a, dut_b, dut_sum;
  logic             dut_cin, dut_cout;
  logic             busy, done, pass, first_fail_valid;
  logic [CNT_W-1:0] err_count;
  logic [VEC_W-1:0] first_fail_vec;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;  // 0 good, 1 cout stuck-0, 2 sum[0] stuck-0, 3 single wrong sum
  int cyc;

  always #5 clk = ~clk;

  cla_bist_checker u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_cin          (dut_cin),
    .dut_sum          (dut_sum),
    .dut_cout         (dut_cout),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  logic [WIDTH:0] add_r;
  always_comb begin
    add_r = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    case (mode)
      1: add_r[WIDTH] = 1'b0;
      2: add_r[0]     = 1'b0;
      3: if (dut_a == 4'd5 && dut_b == 4'd6 && dut_cin) add_r = add_r ^ 5'd1;
      default: ;
    endcase
  end
  assign {dut_cout, dut_sum} = add_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"},  32'(err_count), 0);
    chk({tag, "_ffv"},  32'(first_fail_valid), 0);
    chk({tag, "_ffvec"}, 32'(first_fail_vec), 0);
    chk({tag, "_dut"},  32'({dut_cin, dut_a, dut_b}), 0);
  endtask

  // Pulse start, then count edges after E0 until done; optionally re-pulse
  // start while the vector with index restart_at is on the adder.
  task automatic run(input int restart_at, output int cycles);
    logic busy_ok;
    busy_ok = 1'b1;
    cycles  = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (c - 1 == restart_at) begin
        @(negedge clk); start = 1'b1;
      end
      if (!busy || done) busy_ok = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      if (done) begin
        cycles = c;
        break;
      end
    end
    chk("busy_during_run", 32'(busy_ok), 1);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1; chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Good adder
    mode = 0;
    run(-1, cyc);
    chk("good_latency", cyc, 512);
    chk("good_pass", 32'(pass), 1);
    chk("good_err", 32'(err_count), 0);
    chk("good_ffv", 32'(first_fail_valid), 0);
    chk("good_hold", 32'({dut_cin, dut_a, dut_b}), 32'h1FF);

    // cout stuck-at-0
    mode = 1;
    run(-1, cyc);
    chk("cout_latency", cyc, 512);
    chk("cout_err", 32'(err_count), 256);
    chk("cout_ffv", 32'(first_fail_valid), 1);
    chk("cout_ffvec", 32'(first_fail_vec), 31);
    chk("cout_ff_a", 32'(first_fail_vec[VEC_A_LSB +: WIDTH]), 1);
    chk("cout_ff_b", 32'(first_fail_vec[VEC_B_LSB +: WIDTH]), 15);
    chk("cout_pass", 32'(pass), 0);

    // start in DONE clears results on its edge
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("restart_done", 32'(done), 0);
    chk("restart_err", 32'(err_count), 0);
    chk("restart_ffv", 32'(first_fail_valid), 0);
    chk("restart_busy", 32'(busy), 1);

    // rst while vector 100 is driven
    mode = 0;
    repeat (100) @(posedge clk);
    #1; chk("mid_vec", 32'({dut_cin, dut_a, dut_b}), 100);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("midrst");
    @(negedge clk); rst = 1'b0;

    // rst and start together: rst wins
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    chk("rst_wins_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("rst_wins_idle", 32'(busy), 0);

    run(-1, cyc);
    chk("after_rst_latency", cyc, 512);
    chk("after_rst_pass", 32'(pass), 1);

    // sum[0] stuck-at-0
    mode = 2;
    run(-1, cyc);
    chk("sum0_err", 32'(err_count), 256);
    chk("sum0_ffvec", 32'(first_fail_vec), 1);
    chk("sum0_pass", 32'(pass), 0);

    // start re-pulsed during RUN is ignored
    mode = 0;
    run(50, cyc);
    chk("repulse_latency", cyc, 512);
    chk("repulse_pass", 32'(pass), 1);
    chk("repulse_err", 32'(err_count), 0);

    // Single faulty vector a=5, b=6, cin=1
    mode = 3;
    run(-1, cyc);
    chk("single_err", 32'(err_count), 1);
    chk("single_ffv", 32'(first_fail_valid), 1);
    chk("single_ffvec", 32'(first_fail_vec), 342);
    chk("single_ff_cin", 32'(first_fail_vec[VEC_CIN_BIT]), 1);
    chk("single_pass", 32'(pass), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_bist_checker.md
Name: cla_bist_checker

Overview:
- Built-in self-test engine for the 4-bit carry look-ahead adder: it drives the adder's inputs and checks its outputs, the reverse of the adder's role.
- On `start`, walks every (a, b, cin) combination, presents each to the adder and compares sum/cout against a golden a+b+cin.
- Counts mismatches, records the first failing vector, and reports pass/fail.
- Sits beside the adder in the lab top level as a hardware replacement for hand-written stimulus benches.

Parameters:
- WIDTH, 4, operand width of the adder under test
- VEC_W, 2*WIDTH+1, vector index width (derived; do not override)
- CNT_W, 2*WIDTH+2, error counter width; holds 2^VEC_W without overflow

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; sampled in IDLE or DONE only
- dut_a  output  WIDTH  operand a to the adder
- dut_b  output  WIDTH  operand b to the adder
- dut_cin  output  1  carry-in to the adder
- dut_sum  input  WIDTH  sum from the adder (combinational response)
- dut_cout  input  1  carry-out from the adder
- busy  output  1  high while in RUN
- done  output  1  high in DONE until next start or rst
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  CNT_W  number of mismatching vectors
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_vec  output  VEC_W  index of first mismatching vector

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0, state IDLE, vector index 0.
- Vector encoding: vec[VEC_W-1]=cin, vec[2W-1:W]=a, vec[W-1:0]=b. dut_a/dut_b/dut_cin are registered decodes of the current index.
- Expected result: {cout,sum} = a + b + cin, computed at WIDTH+1 bits, no truncation before compare.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0: go to RUN; clear index, err_count, first_fail_*; drive vector 0; busy=1.
- RUN: the vector is driven for exactly one cycle. The adder is combinational, so the compare happens at the edge ending that cycle. At that edge:
  - mismatch → err_count+1;
  - if first_fail_valid==0 → first_fail_vec=index, first_fail_valid=1;
  - then index+1 and the next vector is driven.
- Last vector (all ones) compared: go to DONE; busy=0, done=1, pass=(final err_count==0). The mismatch of the last vector is included in pass.
- Latency: done rises 2^VEC_W edges after E0; 512 for WIDTH=4.
- start while in RUN: ignored; no restart, no counter effect.
- start in DONE: same as from IDLE; clears results, done=0 and pass=0 on that edge.
- dut_* in DONE/IDLE: hold the last driven vector (IDLE after reset: zeros).
- rst mid-run: next edge → IDLE with all outputs at reset values; partial results discarded.
- rst and start on the same edge: rst wins.
- err_count cannot overflow by sizing; no saturation logic.

Decomposition:
- Package cla_bist_pkg holds:
  - WIDTH default;
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - field-position constants for the cin/a/b slices of the vector index.
- Sub-module cla_golden_ref (WIDTH): purely combinational a+b+cin → {cout,sum}. It keeps the reference model separate from the DUT and is reused by benches.
- FSM, index counter and result registers stay in the top module.

Test Plan:
- Correct behavioural adder connected, start pulse → busy for 512 cycles, done=1 at edge 512, pass=1, err_count=0, first_fail_valid=0.
- Adder with cout stuck-at-0 → err_count=256, first_fail_vec=31 (a=1,b=15,cin=0), pass=0.
- Adder with sum[0] stuck-at-0 → err_count=256, first_fail_vec=1 (a=0,b=1,cin=0), pass=0.
- rst asserted at vector 100 → next edge all outputs 0, state IDLE; subsequent start gives a full 512-cycle run with pass=1.
- start re-pulsed at vector 50 during RUN → ignored; done still at edge 512 from the original start. A start in DONE after a faulty run clears err_count to 0 and done to 0.
- Single-vector fault (adder returns wrong sum only for a=5,b=6,cin=1, correct=12) → err_count=1, first_fail_vec=0x156=342.
